imem_loader: RTL

Boot-time program loader that fills the 4 KB instruction memory from a byte stream and holds the CPU in reset until the load completes. It sits between an external byte source (host link or boot ROM streamer) and the instruction memory write port. It is the writer side of the instruction-fetch path: the CPU reads words at index PC[11:2], and this block writes the same 10-bit word index. A checksum guards the image; on any error the CPU is never released.

---
 rtl/imem_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader: parses [N:16][N words BE][xor byte] from a byte stream into instruction memory.
// One byte per cycle; im_we one cycle after a word's last byte; in_ready drops in DONE/ERR and during rst.
module imem_loader #(
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [9:0]  im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  count_hi;
  logic [9:0]  last_idx;
  logic [9:0]  word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_buf;
  logic [7:0]  xor_acc;
  logic [15:0] n_in;
  logic        accept;

  assign n_in   = {count_hi, in_data};
  assign accept = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    if (!rst) begin
      in_ready = (state == S_HDR0) || (state == S_HDR1) ||
                 (state == S_DATA) || (state == S_CSUM);
    end
    case (state)
      S_HDR0: if (accept) state_nxt = S_HDR1;
      S_HDR1: begin
        if (accept) begin
          if ({1'b0, n_in} > MAX_N)  state_nxt = S_ERR;
          else if (n_in == 16'd0)    state_nxt = S_CSUM;
          else                       state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && byte_cnt == 2'd3 && word_cnt == last_idx) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (accept) state_nxt = (in_data == xor_acc) ? S_DONE : S_ERR;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_HDR0;
      count_hi <= 8'd0;
      last_idx <= 10'd0;
      word_cnt <= 10'd0;
      byte_cnt <= 2'd0;
      asm_buf  <= 24'd0;
      xor_acc  <= 8'd0;
      im_we    <= 1'b0;
      im_addr  <= 10'd0;
      im_wdata <= 32'd0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_rst  <= 1'b1;
    end else begin
      state   <= state_nxt;
      im_we   <= 1'b0;
      // Release outputs come straight from flops so cpu_rst and done switch together.
      done    <= (state_nxt == S_DONE);
      err     <= (state_nxt == S_ERR);
      cpu_rst <= (state_nxt != S_DONE);
      if (accept) begin
        case (state)
          S_HDR0: begin
            count_hi <= in_data;
            xor_acc  <= xor_acc ^ in_data;
          end
          S_HDR1: begin
            last_idx <= 10'(n_in - 16'd1);
            word_cnt <= 10'd0;
            byte_cnt <= 2'd0;
            xor_acc  <= xor_acc ^ in_data;
          end
          S_DATA: begin
            xor_acc  <= xor_acc ^ in_data;
            asm_buf  <= {asm_buf[15:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              im_we    <= 1'b1;
              im_addr  <= word_cnt;
              im_wdata <= {asm_buf, in_data};
              if (word_cnt != last_idx) word_cnt <= word_cnt + 10'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
